// File: rtl/conjugation_sequencer_cba.sv
// Clifford conjugation sequencer: rotates the tableau array one column per cycle and
// substitutes updated literals / phase toggles for H, S and CNOT. Pauli gates via CONJ_PAULI_GATE_EN.
module conj_row (
  input  logic       do_h,
  input  logic       do_s,
  input  logic       do_ca,
  input  logic       do_cb,
  input  logic       do_p,
  input  logic [1:0] lit,
  input  logic [1:0] bc,
  input  logic [1:0] bt,
  input  logic [1:0] pauli,
  output logic [1:0] upd,
  output logic       ph
);
  // literal bit 1 = x, bit 0 = z
  always_comb begin
    upd = 2'b00;
    ph  = 1'b0;
    if (do_h) begin
      upd = {lit[0], lit[1]};
      ph  = lit[1] & lit[0];
    end
    if (do_s) begin
      upd = {lit[1], lit[1] ^ lit[0]};
      ph  = lit[1] & lit[0];
    end
    if (do_ca) begin
      upd = {bc[1], bc[0] ^ bt[0]};
      ph  = bc[1] & bt[0] & ~(bt[1] ^ bc[0]);
    end
    if (do_cb) upd = {bt[1] ^ bc[1], bt[0]};
    if (do_p)  ph = (pauli[1] & lit[0]) ^ (pauli[0] & lit[1]);
  end
endmodule

module conjugation_sequencer_cba #(
  parameter int num_qubit = 4,
  parameter int QW        = (num_qubit > 2) ? $clog2(num_qubit) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gate_valid,
  output logic                       gate_ready,
  input  logic [1:0]                 gate_type,
  input  logic [QW-1:0]              qubit_a,
  input  logic [QW-1:0]              qubit_b,
  input  logic [num_qubit-1:0][1:0]  left_out,
  output logic                       ld_literal,
  output logic [num_qubit-1:0]       ld_phase,
  output logic                       shift_rotate_literal,
  output logic                       shift_toggle_phase,
  output logic                       rotate_update_literal,
  output logic [num_qubit-1:0][1:0]  update_literal,
  output logic                       done,
  output logic                       err
);
  localparam logic [QW:0]   NQ   = (QW+1)'(num_qubit);
  localparam logic [QW-1:0] LAST = QW'(num_qubit - 1);
  localparam logic [1:0]    G_H = 2'd0, G_S = 2'd1, G_CNOT = 2'd2;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  state_t state, state_n;

  logic [QW-1:0] col, a_q, b_q;
  logic [1:0]    typ_q;
  logic          err_q;
  logic [num_qubit-1:0][1:0] buf_c, buf_t;
  logic          accept, legal, a_ok, b_ok, in_pass, hit_a, hit_b;
  logic          do_h, do_s, do_ca, do_cb, do_p;
  logic [1:0]    pauli_q;

  assign a_ok   = {1'b0, qubit_a} < NQ;
  assign b_ok   = {1'b0, qubit_b} < NQ;
  assign accept = gate_valid & (state == IDLE);

  always_comb begin
    case (gate_type)
      G_H, G_S: legal = a_ok;
      G_CNOT:   legal = a_ok & b_ok & (qubit_a != qubit_b);
`ifdef CONJ_PAULI_GATE_EN
      default:  legal = a_ok;
`else
      default:  legal = 1'b0;
`endif
    endcase
  end

`ifdef CONJ_PAULI_GATE_EN
  localparam logic [1:0] G_PAULI = 2'd3;
  logic [1:0] pb, pauli_sel;
  if (QW >= 2) begin : g_pb
    assign pb = qubit_b[1:0];
  end else begin : g_pb1
    assign pb = {1'b0, qubit_b[0]};
  end
  // selector 1 X, 2 Y, 3 Z mapped to the {x,z} literal; 0 is identity
  always_comb begin
    case (pb)
      2'd1:    pauli_sel = 2'b10;
      2'd2:    pauli_sel = 2'b11;
      2'd3:    pauli_sel = 2'b01;
      default: pauli_sel = 2'b00;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pauli_q <= 2'b00;
    else if (accept) pauli_q <= pauli_sel;
  end
  assign do_p = (state == PASS1) && (typ_q == G_PAULI) && hit_a;
`else
  assign pauli_q = 2'b00;
  assign do_p    = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gate_valid) state_n = legal ? PASS1 : DONE;
      PASS1:   if (col == LAST) state_n = (typ_q == G_CNOT) ? PASS2 : DONE;
      PASS2:   if (col == LAST) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  assign in_pass = (state == PASS1) || (state == PASS2);
  assign hit_a   = (col == a_q);
  assign hit_b   = (col == b_q);
  assign do_h    = (state == PASS1) && (typ_q == G_H) && hit_a;
  assign do_s    = (state == PASS1) && (typ_q == G_S) && hit_a;
  // only CNOT reaches PASS2, and a != b so these never coincide
  assign do_ca   = (state == PASS2) && hit_a;
  assign do_cb   = (state == PASS2) && hit_b;

  assign gate_ready            = (state == IDLE);
  assign ld_literal            = in_pass;
  assign shift_rotate_literal  = in_pass;
  assign shift_toggle_phase    = in_pass;
  assign rotate_update_literal = do_h | do_s | do_ca | do_cb;
  assign done                  = (state == DONE);
  assign err                   = (state == DONE) & err_q;

  for (genvar r = 0; r < num_qubit; r++) begin : g_row
    conj_row u_row (
      .do_h  (do_h),
      .do_s  (do_s),
      .do_ca (do_ca),
      .do_cb (do_cb),
      .do_p  (do_p),
      .lit   (left_out[r]),
      .bc    (buf_c[r]),
      .bt    (buf_t[r]),
      .pauli (pauli_q),
      .upd   (update_literal[r]),
      .ph    (ld_phase[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      typ_q <= G_H;
      err_q <= 1'b0;
      buf_c <= '0;
      buf_t <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        typ_q <= gate_type;
        a_q   <= qubit_a;
        b_q   <= qubit_b;
        err_q <= ~legal;
      end
      if (in_pass) col <= (col == LAST) ? '0 : col + QW'(1);
      // PASS2 must see pre-gate control/target literals, captured on the first rotation
      if ((state == PASS1) && hit_a) buf_c <= left_out;
      if ((state == PASS1) && hit_b) buf_t <= left_out;
    end
  end
endmodule

// File: tb/tb_conjugation_sequencer_cba.sv
// Bench for conjugation_sequencer_cba: drives a tableau array model and checks each gate
// against a Pauli-algebra reference (i-power bookkeeping), plus handshake/latency/reset behaviour.
`timescale 1ns/1ps
module tb_conjugation_sequencer_cba;
  localparam int N  = 4;
  localparam int QW = 2;
  typedef logic [N-1:0][N-1:0][1:0] tab_t;
  typedef struct packed { logic ph; logic [N-1:0][1:0] lit; } row_t;
`ifdef CONJ_PAULI_GATE_EN
  localparam bit PAULI_OK = 1'b1;
`else
  localparam bit PAULI_OK = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic gate_valid, gate_ready, ld_literal, shift_rotate_literal, shift_toggle_phase;
  logic rotate_update_literal, done, err;
  logic [1:0] gate_type;
  logic [QW-1:0] qubit_a, qubit_b;
  logic [N-1:0][1:0] left_out, update_literal;
  logic [N-1:0] ld_phase;

  tab_t arr, tb_arr;
  logic [N-1:0] ph, tb_ph;
  logic tb_load = 1'b0;
  int cyc = 0, checks = 0, errors = 0, prev_acc = -100, prev_lat = 0;
  logic [18:0] obus;
  localparam logic [18:0] IDLE_OUT = 19'h40000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conjugation_sequencer_cba #(.num_qubit(N)) dut (
    .clk(clk), .rst(rst), .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_type(gate_type), .qubit_a(qubit_a), .qubit_b(qubit_b), .left_out(left_out),
    .ld_literal(ld_literal), .ld_phase(ld_phase), .shift_rotate_literal(shift_rotate_literal),
    .shift_toggle_phase(shift_toggle_phase), .rotate_update_literal(rotate_update_literal),
    .update_literal(update_literal), .done(done), .err(err)
  );

  assign obus = {gate_ready, ld_literal, ld_phase, shift_rotate_literal, shift_toggle_phase,
                 rotate_update_literal, update_literal, done, err};

  // tableau register array: rotate-left per row, right input from update or wrap-around
  always_comb for (int r = 0; r < N; r++) left_out[r] = arr[r][0];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      arr <= '0;
      ph  <= '0;
    end else if (tb_load) begin
      arr <= tb_arr;
      ph  <= tb_ph;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (ld_literal && shift_rotate_literal) begin
          for (int c = 0; c < N-1; c++) arr[r][c] <= arr[r][c+1];
          arr[r][N-1] <= rotate_update_literal ? update_literal[r] : arr[r][0];
        end
        if (shift_toggle_phase && ld_phase[r]) ph[r] <= ~ph[r];
      end
    end
  end

  // Row = i^e * prod X^x Z^z with e counting Y's (Y = iXZ); map generators, reorder, re-count Y's.
  function automatic row_t ref_conj(row_t r, int g, int a, int b);
    row_t o;
    int xa, za, xb, zb, nxa, nza, nxb, nzb, e, px, pz;
    o  = r;
    xa = int'(r.lit[a][1]); za = int'(r.lit[a][0]);
    xb = int'(r.lit[b][1]); zb = int'(r.lit[b][0]);
    e  = 0;
    case (g)
      0: begin
        e = xa*za + 2*xa*za;
        o.lit[a] = 2'(za*2 + xa);
        e -= za*xa;
      end
      1: begin
        e = xa*za + xa;
        nza = xa ^ za;
        o.lit[a] = 2'(xa*2 + nza);
        e -= xa*nza;
      end
      2: begin
        e = xa*za + xb*zb;
        nxa = xa; nza = za ^ zb; nxb = xa ^ xb; nzb = zb;
        o.lit[a] = 2'(nxa*2 + nza);
        o.lit[b] = 2'(nxb*2 + nzb);
        e -= nxa*nza + nxb*nzb;
      end
      default: begin
        case (b % 4)
          1: begin px = 1; pz = 0; end
          2: begin px = 1; pz = 1; end
          3: begin px = 0; pz = 1; end
          default: begin px = 0; pz = 0; end
        endcase
        e = 2 * ((px*za + pz*xa) % 2);
      end
    endcase
    if ((((e % 4) + 4) % 4) == 2) o.ph = ~o.ph;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_gate(input int g, input int a, input int b, input tab_t t,
                          input logic [N-1:0] p, input bit b2b);
    bit legal, busy_rdy;
    int exp_lat, exp_ld, lat, nld, nstb, acc;
    tab_t et;
    logic [N-1:0] ep;
    row_t rr;
    legal = (a < N) && (g == 0 || g == 1 || (g == 2 && b < N && a != b) || (g == 3 && PAULI_OK));
    et = t; ep = p;
    if (legal) for (int r = 0; r < N; r++) begin
      rr.lit = t[r]; rr.ph = p[r];
      rr = ref_conj(rr, g, a, b);
      et[r] = rr.lit; ep[r] = rr.ph;
    end
    exp_lat = !legal ? 1 : (g == 2 ? 2*N + 1 : N + 1);
    exp_ld  = !legal ? 0 : (g == 2 ? 2*N : N);
    tb_arr = t; tb_ph = p; tb_load = 1'b1;
    if (!b2b) begin
      @(posedge clk); #1;
      chk("ready_after_done", 64'(gate_ready), 64'(1));
    end
    gate_type = 2'(g); qubit_a = QW'(a); qubit_b = QW'(b); gate_valid = 1'b1;
    lat = 0;
    while (!gate_ready && lat < 4) begin @(posedge clk); #1; lat++; end
    chk("ready_wait", 64'(gate_ready), 64'(1));
    @(posedge clk); #1;
    acc = cyc;
    tb_load = 1'b0;
    if (b2b) chk("b2b_spacing", 64'(acc - prev_acc), 64'(prev_lat + 1));
    // scrambled request stays valid while busy: must be ignored, latched values used
    gate_type = 2'($urandom); qubit_a = QW'($urandom); qubit_b = QW'($urandom);
    lat = 1; nld = 0; nstb = 0; busy_rdy = 1'b0;
    while (!done && lat < 3*N) begin
      busy_rdy |= gate_ready;
      nld  += int'(ld_literal);
      nstb += int'(|ld_phase) + int'(rotate_update_literal);
      @(posedge clk); #1; lat++;
    end
    gate_valid = 1'b0;
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("err", 64'(err), 64'(!legal));
    chk("ld_cycles", 64'(nld), 64'(exp_ld));
    if (!legal) chk("no_strobes", 64'(nstb), 64'(0));
    chk("busy_ready", 64'(busy_rdy), 64'(0));
    chk("ready_in_done", 64'(gate_ready), 64'(0));
    chk("tableau", 64'(arr), 64'(et));
    chk("phases", 64'(ph), 64'(ep));
    prev_acc = acc; prev_lat = exp_lat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab_t t;
    gate_valid = 1'b0; gate_type = '0; qubit_a = '0; qubit_b = '0;
    tb_arr = '0; tb_ph = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(obus), 64'(IDLE_OUT));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", 64'(obus), 64'(IDLE_OUT));

    // H q1: X -> Z
    t = '0; t[0][1] = 2'b10;
    run_gate(0, 1, 0, t, '0, 1'b0);
    chk("h_lit", 64'(arr[0][1]), 64'(2'b01));
    chk("h_ph", 64'(ph[0]), 64'(0));

    // S q2: Y -> -X, other rows unchanged
    t = '0; t[0][2] = 2'b11; t[1][2] = 2'b01; t[2][0] = 2'b10;
    run_gate(1, 2, 0, t, '0, 1'b0);
    chk("s_lit", 64'(arr[0][2]), 64'(2'b10));
    chk("s_ph", 64'(ph[0]), 64'(1));
    chk("s_others", 64'(arr[3:1]), 64'(t[3:1]));

    // CNOT 0->3: X0 -> X0X3, Z3 -> Z0Z3
    t = '0; t[0][0] = 2'b10; t[1][3] = 2'b01;
    run_gate(2, 0, 3, t, '0, 1'b0);
    chk("cx03_r0c3", 64'(arr[0][3]), 64'(2'b10));
    chk("cx03_r1c0", 64'(arr[1][0]), 64'(2'b01));
    chk("cx03_ph", 64'(ph[1:0]), 64'(0));

    // CNOT 3->0: Z0X3 -> -Y0Y3
    t = '0; t[0][0] = 2'b01; t[0][3] = 2'b10;
    run_gate(2, 3, 0, t, '0, 1'b0);
    chk("cx30_c0", 64'(arr[0][0]), 64'(2'b11));
    chk("cx30_c3", 64'(arr[0][3]), 64'(2'b11));
    chk("cx30_ph", 64'(ph[0]), 64'(1));

    // illegal CNOT a==b, then gate type 3, back to back
    run_gate(2, 2, 2, tab_t'($urandom), N'($urandom), 1'b1);
    run_gate(3, 1, 2, tab_t'($urandom), N'($urandom), 1'b1);

    // rst in PASS2 col 1
    tb_arr = tab_t'($urandom); tb_ph = N'($urandom); tb_load = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_ready", 64'(gate_ready), 64'(1));
    gate_type = 2'd2; qubit_a = 2'd1; qubit_b = 2'd2; gate_valid = 1'b1;
    @(posedge clk); #1;
    tb_load = 1'b0; gate_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_pass_busy", 64'(ld_literal), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 64'(obus), 64'(IDLE_OUT));
    chk("rst_mid_array", 64'({arr, ph}), 64'(0));
    #2 rst = 1'b0;
    t = '0; t[2][3] = 2'b11; t[1][3] = 2'b10;
    run_gate(0, 3, 0, t, 4'b0101, 1'b0);

    for (int i = 0; i < 40; i++)
      run_gate(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               tab_t'($urandom), N'($urandom), bit'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
